// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    // Fetch sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // All-zero word decodes as sll $0,$0,0 and is used as the pipeline bubble.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Instruction field bit positions.
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Fetch/decode pipeline register: holds one instruction and its PC+4.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out
);
    logic        valid_d, valid_q;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc4_d, pc4_q;

    // Flush beats load; an invalid load writes a clean bubble; otherwise hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pc4_d   = '0;
        end else if (load) begin
            valid_d = valid_in;
            instr_d = valid_in ? instr_in : NOP_WORD;
            pc4_d   = valid_in ? pc_plus4_in : '0;
        end
    end

    // Register update with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_out    = valid_q;
    assign instr_out    = instr_q;
    assign pc_plus4_out = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fetch sequencer, skid buffer, decode register.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | first cycle out of reset, no request issued
// ST_FETCH | request outstanding at PC; an ack advances PC
// ST_HOLD  | acked word parked in skid buffer while downstream stalls
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         instr_valid,
    output logic [5:0]   instr_op,
    output logic [4:0]   instr_rs,
    output logic [4:0]   instr_rt,
    output logic [4:0]   instr_rd,
    output logic [15:0]  instr_imm,
    output logic [5:0]   instr_funct,
    output logic [31:0]  pc_plus4
);
    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  skid_instr_d, skid_instr_q;
    logic [31:0]  skid_pc4_d, skid_pc4_q;
    logic         req_d, req_q;
    logic [31:0]  pc_inc;

    logic         dec_load;
    logic         dec_flush;
    logic         dec_valid_in;
    logic [31:0]  dec_instr_in;
    logic [31:0]  dec_pc4_in;
    logic [31:0]  dec_instr;

    assign pc_inc = pc_q + PC_STEP;

    // Next-state, PC, skid buffer and decode-register control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        dec_load     = 1'b0;
        dec_flush    = 1'b0;
        dec_valid_in = 1'b0;
        dec_instr_in = NOP_WORD;
        dec_pc4_in   = '0;
        if (branch_taken) begin
            // Redirect wins over stall and ack; any word in flight is dropped.
            pc_d         = word_align(branch_target);
            state_d      = ST_FETCH;
            skid_instr_d = NOP_WORD;
            skid_pc4_d   = '0;
            dec_flush    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_instr_d = imem.imem_rdata;
                            skid_pc4_d   = pc_inc;
                            state_d      = ST_HOLD;
                        end else begin
                            dec_load     = 1'b1;
                            dec_valid_in = 1'b1;
                            dec_instr_in = imem.imem_rdata;
                            dec_pc4_in   = pc_inc;
                        end
                    end else if (!stall) begin
                        // Downstream took the held instruction and nothing new arrived.
                        dec_load = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        dec_load     = 1'b1;
                        dec_valid_in = 1'b1;
                        dec_instr_in = skid_instr_q;
                        dec_pc4_in   = skid_pc4_q;
                        skid_instr_d = NOP_WORD;
                        skid_pc4_d   = '0;
                        state_d      = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        req_d = (state_d == ST_FETCH);
    end

    // Sequencer state, PC, skid buffer and registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= word_align(RESET_PC);
            skid_instr_q <= NOP_WORD;
            skid_pc4_q   <= '0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            req_q        <= req_d;
        end
    end

    fetch_unit_if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (dec_load),
        .flush        (dec_flush),
        .valid_in     (dec_valid_in),
        .instr_in     (dec_instr_in),
        .pc_plus4_in  (dec_pc4_in),
        .valid_out    (instr_valid),
        .instr_out    (dec_instr),
        .pc_plus4_out (pc_plus4)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign instr_op    = dec_instr[OP_MSB:OP_LSB];
    assign instr_rs    = dec_instr[RS_MSB:RS_LSB];
    assign instr_rt    = dec_instr[RT_MSB:RT_LSB];
    assign instr_rd    = dec_instr[RD_MSB:RD_LSB];
    assign instr_imm   = dec_instr[IMM_MSB:IMM_LSB];
    assign instr_funct = dec_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table plus randomized scoreboard run.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [5:0]  instr_op;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;
    logic [15:0] instr_imm;
    logic [5:0]  instr_funct;
    logic [31:0] pc_plus4;
    logic [31:0] act_word;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_op      (instr_op),
        .instr_rs      (instr_rs),
        .instr_rt      (instr_rt),
        .instr_rd      (instr_rd),
        .instr_imm     (instr_imm),
        .instr_funct   (instr_funct),
        .pc_plus4      (pc_plus4)
    );

    assign act_word = {instr_op, instr_rs, instr_rt, instr_imm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    localparam int NV = 25;
    vec_t vecs [NV];
    exp_t exp_q [$];
    sb_t  sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic s, input logic b, input logic [31:0] t,
                                input logic xr, input logic [31:0] xa, input logic xv,
                                input logic [31:0] xi, input logic [31:0] xp);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.stall = s; v.br = b; v.tgt = t;
        v.e.req = xr; v.e.addr = xa; v.e.valid = xv; v.e.instr = xi; v.e.pc4 = xp;
        return v;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        logic ok;
        ok = (bus.imem_req === e.req) && (bus.imem_addr === e.addr) &&
             (instr_valid === e.valid) && (act_word === e.instr) &&
             (instr_rd === e.instr[15:11]) && (instr_funct === e.instr[5:0]) &&
             (pc_plus4 === e.pc4);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h rd=%h funct=%h pc4=%h; want req=%0b addr=%h valid=%0b instr=%h pc4=%h",
                     name, bus.imem_req, bus.imem_addr, instr_valid, act_word, instr_rd,
                     instr_funct, pc_plus4, e.req, e.addr, e.valid, e.instr, e.pc4);
        end
    endtask

    logic [31:0] model_pc;
    sb_t         ent;
    sb_t         front;

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;

        //               rst ack rdata         stall br tgt           | req addr          valid instr         pc4
        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h40,        0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 1, 32'hDEAD_BEEF, 1, 1, 32'h200,       0, 32'h40,        0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 1, 32'h8C22_0004, 0, 0, 32'h0,         1, 32'h44,        1, 32'h8C22_0004, 32'h44);
        vecs[4]  = mk(0, 1, 32'hAC22_0008, 0, 0, 32'h0,         1, 32'h48,        1, 32'hAC22_0008, 32'h48);
        vecs[5]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h48,        0, 32'h0,         32'h0);
        vecs[6]  = mk(0, 1, 32'h2063_0001, 0, 0, 32'h0,         1, 32'h4C,        1, 32'h2063_0001, 32'h4C);
        vecs[7]  = mk(0, 1, 32'h1022_0003, 1, 0, 32'h0,         0, 32'h50,        1, 32'h2063_0001, 32'h4C);
        vecs[8]  = mk(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 32'h50,        1, 32'h2063_0001, 32'h4C);
        vecs[9]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h50,        1, 32'h2063_0001, 32'h4C);
        vecs[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h50,        1, 32'h1022_0003, 32'h50);
        vecs[11] = mk(0, 1, 32'h0000_0020, 0, 1, 32'h103,       1, 32'h100,       0, 32'h0,         32'h0);
        vecs[12] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        vecs[13] = mk(0, 1, 32'h0043_0825, 0, 0, 32'h0,         1, 32'h0,         1, 32'h0043_0825, 32'h0);
        vecs[14] = mk(1, 1, 32'h8C22_0004, 0, 0, 32'h0,         0, 32'h40,        0, 32'h0,         32'h0);
        vecs[15] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0);
        vecs[16] = mk(0, 1, 32'h1022_0003, 1, 0, 32'h0,         0, 32'h44,        0, 32'h0,         32'h0);
        vecs[17] = mk(0, 0, 32'h0,         1, 1, 32'h80,        1, 32'h80,        0, 32'h0,         32'h0);
        vecs[18] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h80,        0, 32'h0,         32'h0);
        vecs[19] = mk(0, 1, 32'hAC22_0008, 0, 0, 32'h0,         1, 32'h84,        1, 32'hAC22_0008, 32'h84);
        vecs[20] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h84,        1, 32'hAC22_0008, 32'h84);
        vecs[21] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h84,        0, 32'h0,         32'h0);
        vecs[22] = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h40,        0, 32'h0,         32'h0);
        vecs[23] = mk(0, 0, 32'h0,         0, 1, 32'h1234_5678, 1, 32'h1234_5678, 0, 32'h0,         32'h0);
        vecs[24] = mk(0, 1, 32'h3C01_1234, 0, 0, 32'h0,         1, 32'h1234_567C, 1, 32'h3C01_1234, 32'h1234_567C);

        for (int i = 0; i < NV; i++) begin
            rst           = vecs[i].rst;
            bus.imem_ack  = vecs[i].ack;
            bus.imem_rdata = vecs[i].rdata;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            exp_q.push_back(vecs[i].e);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), exp_q.pop_front());
        end

        // Random stall/ack/branch traffic checked against an in-order word scoreboard.
        rst = 1'b1; bus.imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_pc = 32'h40;
        sb_q.delete();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                stall         = ($urandom_range(0, 9) < 3);
                branch_taken  = ($urandom_range(0, 24) == 0);
                branch_target = $urandom;
                bus.imem_ack  = ($urandom_range(0, 9) < 7);
                bus.imem_rdata = $urandom;
            end else begin
                stall = 1'b0; branch_taken = 1'b0; bus.imem_ack = 1'b0;
            end
            if (branch_taken) begin
                sb_q.delete();
                model_pc = branch_target & 32'hFFFF_FFFC;
            end else begin
                if (instr_valid && !stall && sb_q.size() > 0) void'(sb_q.pop_front());
                if (bus.imem_req && bus.imem_ack) begin
                    n_vec++;
                    if (bus.imem_addr !== model_pc) begin
                        n_err++;
                        $display("FAIL sb_addr cyc%0d: got addr=%h want %h", c, bus.imem_addr, model_pc);
                    end
                    ent.instr = bus.imem_rdata;
                    ent.pc4   = model_pc + 32'd4;
                    sb_q.push_back(ent);
                    model_pc = model_pc + 32'd4;
                end
            end
            @(posedge clk); #1;
            n_vec++;
            if (instr_valid) begin
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_word cyc%0d: got instr=%h pc4=%h want no valid instruction", c, act_word, pc_plus4);
                end else begin
                    front = sb_q[0];
                    if (act_word !== front.instr || pc_plus4 !== front.pc4) begin
                        n_err++;
                        $display("FAIL sb_word cyc%0d: got instr=%h pc4=%h want instr=%h pc4=%h",
                                 c, act_word, pc_plus4, front.instr, front.pc4);
                    end
                end
            end else if (act_word !== NOP_WORD) begin
                n_err++;
                $display("FAIL sb_bubble cyc%0d: got instr=%h want %h", c, act_word, NOP_WORD);
            end
            if (branch_taken) begin
                n_vec++;
                if (instr_valid !== 1'b0 || bus.imem_addr !== model_pc || bus.imem_req !== 1'b1) begin
                    n_err++;
                    $display("FAIL sb_branch cyc%0d: got valid=%0b req=%0b addr=%h want valid=0 req=1 addr=%h",
                             c, instr_valid, bus.imem_req, bus.imem_addr, model_pc);
                end
            end
        end
        if (instr_valid && sb_q.size() > 0) void'(sb_q.pop_front());
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d words undelivered want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
